aes_out_collector: RTL and testbench

- Downstream stage of the AES controller/core pair. Captures each finished 128-bit ciphertext block when the controller signals `done`.
- Tags each block with the time-interleave slot (0..N-1) it came from and buffers it in a small FIFO.
- Presents buffered blocks to the consumer through a valid/ready handshake.
- Isolates the free-running interleaved core from a consumer that may stall.

---
 rtl/aes_out_collector.sv | 93 +++++++++
 tb/tb_aes_out_collector.sv | 123 ++++++++++++
 2 files changed

// File: rtl/aes_out_collector.sv
// aes_out_collector: slot-tagged FIFO for AES ciphertext blocks, presented through a valid/ready handshake
// Ports: clk, rstn (async, active-low); start/done/data_in come from the AES controller/core;
//        out_valid/out_ready/out_data/out_slot form the consumer side; level is the block count;
//        overflow is a sticky drop flag, cleared by clr_ovf.
// Optional: define AES_OUT_COLLECT_SEQ_EN to add out_seq, a 16-bit push sequence number stored with each block.
module aes_out_collector #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic                                done,
  input  logic [127:0]                        data_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [127:0]                        out_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_slot,
  output logic [$clog2(DEPTH):0]              level,
  output logic                                overflow,
  input  logic                                clr_ovf
`ifdef AES_OUT_COLLECT_SEQ_EN
  ,
  output logic [15:0]                         out_seq
`endif
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [127:0]  mem_data [DEPTH];
  logic [SW-1:0] mem_slot [DEPTH];
  logic [SW-1:0] slot_q, slot_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, full, wr_en;
  always_comb begin
    push     = start & done;
    pop      = out_valid & out_ready;
    full     = level_q == LW'(DEPTH);
    // when full, a simultaneous pop frees the slot the push lands in
    wr_en    = push & (~full | pop);
    slot_d   = start ? ((slot_q == SW'(N - 1)) ? '0 : slot_q + 1'b1) : slot_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(wr_en) - LW'(pop);
    // a drop in the same cycle as clr_ovf keeps the flag set
    ovf_d    = (push & full & ~pop) | (ovf_q & ~clr_ovf);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= data_in;
      mem_slot[wr_ptr_q] <= slot_q;
    end
  end
  // outputs are forced to zero while empty so a never-written head entry cannot leak X
  always_comb begin
    out_valid = level_q != '0;
    out_data  = out_valid ? mem_data[rd_ptr_q] : '0;
    out_slot  = out_valid ? mem_slot[rd_ptr_q] : '0;
    level     = level_q;
    overflow  = ovf_q;
  end
`ifdef AES_OUT_COLLECT_SEQ_EN
  logic [15:0] mem_seq [DEPTH];
  logic [15:0] seq_q, seq_d;
  // dropped blocks still consume a number so the consumer can see the gap
  always_comb seq_d = seq_q + 16'(push);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) seq_q <= '0;
    else seq_q <= seq_d;
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_seq[wr_ptr_q] <= seq_q;
  end
  always_comb out_seq = out_valid ? mem_seq[rd_ptr_q] : '0;
`endif
endmodule

// File: tb/tb_aes_out_collector.sv
// tb_aes_out_collector: scoreboard bench for aes_out_collector
module tb_aes_out_collector;
  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int SW    = $clog2(N);
  localparam int LW    = $clog2(DEPTH) + 1;
  typedef struct {
    logic [127:0]  d;
    logic [SW-1:0] s;
    logic [15:0]   q;
  } blk_t;
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0, done = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [127:0]  data_in = '0;
  logic          out_valid, overflow;
  logic [127:0]  out_data;
  logic [SW-1:0] out_slot;
  logic [LW-1:0] level;
`ifdef AES_OUT_COLLECT_SEQ_EN
  logic [15:0]   out_seq;
`endif
  blk_t          sb [$];
  logic [SW-1:0] slot_m = '0;
  logic [15:0]   seq_m = '0;
  logic          ovf_m = 1'b0;
  int            n_cmp = 0, n_err = 0;
  aes_out_collector #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .done(done), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_slot(out_slot), .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef AES_OUT_COLLECT_SEQ_EN
    , .out_seq(out_seq)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // drive one cycle, check the head against the scoreboard, then advance the model past the edge
  task automatic step(input logic s, input logic d, input logic [127:0] din, input logic r, input logic c);
    bit full, pop, push;
    @(negedge clk);
    start = s; done = d; data_in = din; out_ready = r; clr_ovf = c;
    #1;
    chk("valid", 128'(out_valid), 128'(sb.size() != 0));
    chk("level", 128'(level), 128'(sb.size()));
    chk("overflow", 128'(overflow), 128'(ovf_m));
    if (sb.size() != 0) begin
      chk("data", out_data, sb[0].d);
      chk("slot", 128'(out_slot), 128'(sb[0].s));
`ifdef AES_OUT_COLLECT_SEQ_EN
      chk("seq", 128'(out_seq), 128'(sb[0].q));
`endif
    end
    full = sb.size() == DEPTH;
    pop  = sb.size() != 0 && r;
    push = s && d;
    if (pop) void'(sb.pop_front());
    if (push && (!full || pop)) sb.push_back('{din, slot_m, seq_m});
    ovf_m = (push && full && !pop) || (ovf_m && !c);
    if (push) seq_m++;
    if (s) slot_m = (slot_m == SW'(N - 1)) ? '0 : slot_m + 1'b1;
  endtask
  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    rstn = 1'b1;
    // single block, 1-cycle latency, popped immediately
    step(1, 1, 128'h3925841d02dc09fbdc118597196a0b32, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    // four back-to-back blocks held, then drained in order
    for (int i = 0; i < 4; i++) step(1, 1, rnd(), 0, 0);
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 0);
    // nine pushes into an 8-deep FIFO: one drop, sticky flag, then clear
    for (int i = 0; i < 9; i++) step(1, 1, rnd(), 0, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    // full with simultaneous push and pop: no drop, level stays full
    step(1, 1, rnd(), 1, 0);
    step(0, 0, '0, 0, 0);
    // drop coinciding with clr_ovf keeps the flag
    step(1, 1, rnd(), 0, 1);
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 1);
    // done without start is ignored and the slot counter holds
    step(0, 1, rnd(), 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, rnd(), 0, 0);
    step(0, 0, '0, 0, 0);
    // asynchronous reset mid-cycle with five blocks buffered
    @(negedge clk);
    start = 0; done = 0; #2;
    rstn = 1'b0;
    #1;
    chk("async_valid", 128'(out_valid), 128'(0));
    chk("async_level", 128'(level), 128'(0));
    sb.delete(); slot_m = '0; seq_m = '0; ovf_m = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step(1, 1, rnd(), 0, 0);
    step(0, 0, '0, 1, 0);
    // random traffic with a bias towards filling the FIFO
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), rnd(),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, '0, 1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
